// File: rtl/arb_pkg.sv
// Shared types and AXI field constants for the two-port AXI read arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   localparam logic [1:0] AXI_BURST_WRAP   = 2'h2;
   localparam logic [2:0] AXI_SIZE_8B      = 3'h3;
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'h6;
   localparam logic [1:0] AXI_RESP_OKAY    = 2'h0;

endpackage

// File: rtl/rr_pick2.sv
// Two-way request picker. Round-robin by default; with ARB_FIXED_PRIO_EN
// defined, port 1 (load) always wins a simultaneous request.
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

`ifdef ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant_i;

   // Fixed priority: load port first.
   always_comb begin
      grant_o = 2'b00;
      if (req_i[1]) begin
         grant_o = 2'b10;
      end else if (req_i[0]) begin
         grant_o = 2'b01;
      end
   end
`else
   // Round-robin: on a tie the port that was not granted last wins.
   always_comb begin
      grant_o = req_i;
      if (&req_i) begin
         grant_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between the fetch (port 0) and load (port 1)
// requesters. One WRAP burst per grant, beats routed to the owner only.
// Optional macro: ARB_FIXED_PRIO_EN (load port always wins a tie).
//
// state | meaning
// IDLE  | no burst in flight; arbitrate pending requests
// ADDR  | AR channel valid, waiting for arready
// DATA  | streaming R beats to the owning port until rlast
module axi_rd_arbiter
   import arb_pkg::*;
#(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int BURST_LEN  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   output logic                  req0_ready,
   output logic                  resp0_valid,
   output logic [DATA_WIDTH-1:0] resp0_data,
   output logic                  resp0_last,
   output logic                  resp0_err,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   output logic                  req1_ready,
   output logic                  resp1_valid,
   output logic [DATA_WIDTH-1:0] resp1_data,
   output logic                  resp1_last,
   output logic                  resp1_err,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic                  proto_err
);

   localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

   arb_state_t            state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_grant_q, last_grant_d;
   logic [7:0]            beat_cnt_q, beat_cnt_d;
   logic [ADDR_WIDTH-4:0] addr_q, addr_d;
   logic                  proto_err_q, proto_err_d;
   logic [1:0]            ready_q, ready_d;
   logic [1:0]            grant;
   logic                  sel0, sel1;

   // Beats are routed by owner alone, so rid and the byte offset are not used.
   logic unused_inputs;
   assign unused_inputs = ^{m_axi_rid, req0_addr[2:0], req1_addr[2:0]};

   rr_pick2 u_pick (
      .req_i        ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         beat_cnt_q   <= '0;
         addr_q       <= '0;
         proto_err_q  <= 1'b0;
         ready_q      <= 2'b00;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         addr_q       <= addr_d;
         proto_err_q  <= proto_err_d;
         ready_q      <= ready_d;
      end
   end

   // Next-state logic: grant, address handshake, beat counting and rlast checking.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      addr_d       = addr_q;
      proto_err_d  = proto_err_q;
      ready_d      = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (|grant) begin
               owner_d = grant[1];
               addr_d  = grant[1] ? req1_addr[ADDR_WIDTH-1:3] : req0_addr[ADDR_WIDTH-1:3];
               ready_d = grant;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (m_axi_arready) begin
               beat_cnt_d = '0;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (m_axi_rvalid) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (m_axi_rlast) begin
                  if (beat_cnt_q != LAST_BEAT) begin
                     proto_err_d = 1'b1;
                  end
                  last_grant_d = owner_q;
                  state_d      = IDLE;
               end else if (beat_cnt_q == LAST_BEAT) begin
                  proto_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sel0 = m_axi_rvalid && (state_q == DATA) && !owner_q;
   assign sel1 = m_axi_rvalid && (state_q == DATA) && owner_q;

   assign req0_ready  = ready_q[0];
   assign req1_ready  = ready_q[1];

   assign resp0_valid = sel0;
   assign resp0_data  = sel0 ? m_axi_rdata : '0;
   assign resp0_last  = sel0 && m_axi_rlast;
   assign resp0_err   = sel0 && (m_axi_rresp != AXI_RESP_OKAY);
   assign resp1_valid = sel1;
   assign resp1_data  = sel1 ? m_axi_rdata : '0;
   assign resp1_last  = sel1 && m_axi_rlast;
   assign resp1_err   = sel1 && (m_axi_rresp != AXI_RESP_OKAY);

   assign m_axi_arid    = {{(ID_WIDTH-1){1'b0}}, owner_q};
   assign m_axi_araddr  = {addr_q, 3'b000};
   assign m_axi_arlen   = LAST_BEAT;
   assign m_axi_arsize  = AXI_SIZE_8B;
   assign m_axi_arburst = AXI_BURST_WRAP;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'h0;
   assign m_axi_arprot  = AXI_PROT_DEFAULT;
   assign m_axi_arvalid = (state_q == ADDR);
   assign m_axi_rready  = (state_q == DATA);
   assign proto_err     = proto_err_q;

endmodule
